// File: rtl/regs_sb.sv
// regs_sb: parametrised register file with two combinational read ports,
// one enabled write port and a per-register busy scoreboard that flags
// read-after-write hazards against in-flight producers.
// Optional feature macro: REGS_BYPASS_EN (same-cycle write-to-read bypass
// and busy masking on a writeback hit).
module regs_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic [ADDR_W-1:0] i_reg_1_sel,
    input  logic [ADDR_W-1:0] i_reg_2_sel,
    output logic [DATA_W-1:0] o_reg_1,
    output logic [DATA_W-1:0] o_reg_2,
    input  logic              i_reg_w_en,
    input  logic [ADDR_W-1:0] i_reg_w_sel,
    input  logic [DATA_W-1:0] i_reg_w_data,
    input  logic              i_issue_valid,
    input  logic [ADDR_W-1:0] i_issue_rd,
    output logic              o_reg_1_busy,
    output logic              o_reg_2_busy,
    output logic              o_hazard,
    output logic [ADDR_W:0]   o_busy_cnt
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic [CNT_W-1:0]  busy_cnt;
    logic [CNT_W-1:0]  busy_cnt_nxt;

    logic w_ok;
    logic set_ok;
    logic rise;
    logic fall;

    // Qualify write and issue: register 0 is hardwired when ZERO_REG is set
    always_comb begin
        w_ok   = i_reg_w_en    && !(ZERO_REG && (i_reg_w_sel == '0));
        set_ok = i_issue_valid && !(ZERO_REG && (i_issue_rd == '0));
    end

    // Register storage: reset clears every entry, otherwise a qualified write
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[ADDR_W'(i)] <= '0;
            end
        end else if (w_ok) begin
            regs[i_reg_w_sel] <= i_reg_w_data;
        end
    end

    // Scoreboard next state: a new producer supersedes the retiring one
    always_comb begin
        busy_nxt = busy;
        rise     = 1'b0;
        fall     = 1'b0;
        if (i_reg_w_en) begin
            busy_nxt[i_reg_w_sel] = 1'b0;
        end
        if (set_ok) begin
            busy_nxt[i_issue_rd] = 1'b1;
        end
        rise = set_ok && !busy[i_issue_rd];
        fall = i_reg_w_en && busy[i_reg_w_sel]
               && !(set_ok && (i_issue_rd == i_reg_w_sel));
        case ({rise, fall})
            2'b10:   busy_cnt_nxt = busy_cnt + CNT_W'(1);
            2'b01:   busy_cnt_nxt = busy_cnt - CNT_W'(1);
            default: busy_cnt_nxt = busy_cnt;
        endcase
    end

    // Scoreboard state and busy population count
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= busy_cnt_nxt;
        end
    end

    // Read ports: stored value, optional same-cycle bypass, zero register
    always_comb begin
        o_reg_1      = regs[i_reg_1_sel];
        o_reg_2      = regs[i_reg_2_sel];
        o_reg_1_busy = busy[i_reg_1_sel];
        o_reg_2_busy = busy[i_reg_2_sel];
`ifdef REGS_BYPASS_EN
        if (w_ok && (i_reg_1_sel == i_reg_w_sel)) begin
            o_reg_1      = i_reg_w_data;
            o_reg_1_busy = 1'b0;
        end
        if (w_ok && (i_reg_2_sel == i_reg_w_sel)) begin
            o_reg_2      = i_reg_w_data;
            o_reg_2_busy = 1'b0;
        end
`else
`endif
        if (ZERO_REG && (i_reg_1_sel == '0)) begin
            o_reg_1 = '0;
        end
        if (ZERO_REG && (i_reg_2_sel == '0)) begin
            o_reg_2 = '0;
        end
        o_hazard   = o_reg_1_busy | o_reg_2_busy;
        o_busy_cnt = busy_cnt;
    end

endmodule

// File: tb/tb_regs_sb.sv
// Bench for regs_sb: one instance with ZERO_REG=1 (dut_z) and one with
// ZERO_REG=0 (dut_n) share all inputs. Table vectors plus hand sequences;
// expected values are pushed to a scoreboard queue at drive time and popped
// when outputs are sampled just before the next rising edge.
module tb_regs_sb;

`ifdef REGS_BYPASS_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        w_en;
    logic [4:0]  w_sel;
    logic [31:0] w_data;
    logic        iv;
    logic [4:0]  rd;
    logic [4:0]  s1;
    logic [4:0]  s2;

    logic [31:0] z_r1, z_r2, n_r1, n_r2;
    logic        z_b1, z_b2, z_hz, n_b1, n_b2, n_hz;
    logic [5:0]  z_cnt, n_cnt;

    regs_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut_z (
        .i_CLK(clk), .i_RST(rst),
        .i_reg_1_sel(s1), .i_reg_2_sel(s2),
        .o_reg_1(z_r1), .o_reg_2(z_r2),
        .i_reg_w_en(w_en), .i_reg_w_sel(w_sel), .i_reg_w_data(w_data),
        .i_issue_valid(iv), .i_issue_rd(rd),
        .o_reg_1_busy(z_b1), .o_reg_2_busy(z_b2),
        .o_hazard(z_hz), .o_busy_cnt(z_cnt)
    );

    regs_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b0)) dut_n (
        .i_CLK(clk), .i_RST(rst),
        .i_reg_1_sel(s1), .i_reg_2_sel(s2),
        .o_reg_1(n_r1), .o_reg_2(n_r2),
        .i_reg_w_en(w_en), .i_reg_w_sel(w_sel), .i_reg_w_data(w_data),
        .i_issue_valid(iv), .i_issue_rd(rd),
        .o_reg_1_busy(n_b1), .o_reg_2_busy(n_b2),
        .o_hazard(n_hz), .o_busy_cnt(n_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, we;
        logic [4:0]  ws;
        logic [31:0] wd;
        logic        v;
        logic [4:0]  d, a, b;
        logic [31:0] e1, e2;
        logic        eb1, eb2, ehz;
        logic [5:0]  ecnt;
    } vec_t;

    typedef struct {
        int          dut;
        string       name;
        logic [31:0] e1, e2;
        logic        eb1, eb2, ehz;
        logic [5:0]  ecnt;
        bit          full;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[24];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic vec_t mk(logic r, logic we, logic [4:0] ws, logic [31:0] wd,
                                logic v, logic [4:0] d, logic [4:0] a, logic [4:0] b,
                                logic [31:0] e1, logic [31:0] e2,
                                logic eb1, logic eb2, logic ehz, logic [5:0] ecnt);
        vec_t t;
        t.rst = r;  t.we = we; t.ws = ws; t.wd = wd; t.v = v; t.d = d;
        t.a = a;    t.b = b;   t.e1 = e1; t.e2 = e2;
        t.eb1 = eb1; t.eb2 = eb2; t.ehz = ehz; t.ecnt = ecnt;
        return t;
    endfunction

    task automatic drive(input logic r, input logic we, input logic [4:0] ws,
                         input logic [31:0] wd, input logic v, input logic [4:0] d,
                         input logic [4:0] a, input logic [4:0] b);
        @(negedge clk);
        rst = r; w_en = we; w_sel = ws; w_data = wd;
        iv = v;  rd = d;    s1 = a;     s2 = b;
    endtask

    task automatic push(input int dut, input string name,
                        input logic [31:0] e1, input logic [31:0] e2,
                        input logic eb1, input logic eb2, input logic ehz,
                        input logic [5:0] ecnt, input bit full);
        exp_t e;
        e.dut = dut; e.name = name; e.e1 = e1; e.e2 = e2;
        e.eb1 = eb1; e.eb2 = eb2; e.ehz = ehz; e.ecnt = ecnt; e.full = full;
        sb.push_back(e);
    endtask

    task automatic cmp(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s.%s: got %0h expected %0h", name, field, act, exp);
    endtask

    // Sample before the rising edge and drain the scoreboard
    task automatic settle_and_check();
        exp_t        e;
        logic [31:0] r1, r2;
        logic        b1, b2, hz;
        logic [5:0]  c;
        #2;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.dut == 0) begin
                r1 = z_r1; r2 = z_r2; b1 = z_b1; b2 = z_b2; hz = z_hz; c = z_cnt;
            end else begin
                r1 = n_r1; r2 = n_r2; b1 = n_b1; b2 = n_b2; hz = n_hz; c = n_cnt;
            end
            cmp(e.name, "busy_cnt", 32'(c), 32'(e.ecnt));
            if (e.full) begin
                cmp(e.name, "reg_1", r1, e.e1);
                cmp(e.name, "reg_2", r2, e.e2);
                cmp(e.name, "busy_1", 32'(b1), 32'(e.eb1));
                cmp(e.name, "busy_2", 32'(b2), 32'(e.eb2));
                cmp(e.name, "hazard", 32'(hz), 32'(e.ehz));
            end
        end
    endtask

    initial begin
        rst = 1'b1; w_en = 1'b0; w_sel = '0; w_data = '0;
        iv = 1'b0; rd = '0; s1 = '0; s2 = '0;

        // Expected values for dut_z, sampled before the vector's own edge
        vecs[0]  = mk(0,0,5'd0,32'h0,        0,5'd0,5'd1,5'd2, 32'h0,32'h0, 0,0,0,6'd0);
        vecs[1]  = mk(0,1,5'd1,32'h1,        0,5'd0,5'd1,5'd2, BP?32'h1:32'h0,32'h0, 0,0,0,6'd0);
        vecs[2]  = mk(0,1,5'd2,32'h2,        0,5'd0,5'd1,5'd3, 32'h1,32'h0, 0,0,0,6'd0);
        vecs[3]  = mk(0,1,5'd3,32'h3,        0,5'd0,5'd2,5'd3, 32'h2,BP?32'h3:32'h0, 0,0,0,6'd0);
        vecs[4]  = mk(1,1,5'd4,32'h44,       0,5'd0,5'd3,5'd4, 32'h3,BP?32'h44:32'h0, 0,0,0,6'd0);
        vecs[5]  = mk(0,0,5'd0,32'h0,        0,5'd0,5'd3,5'd4, 32'h0,32'h0, 0,0,0,6'd0);
        vecs[6]  = mk(0,1,5'd1,32'd265,      0,5'd0,5'd1,5'd2, BP?32'd265:32'h0,32'h0, 0,0,0,6'd0);
        vecs[7]  = mk(0,1,5'd2,32'hDEADBEEF, 0,5'd0,5'd1,5'd2, 32'd265,BP?32'hDEADBEEF:32'h0, 0,0,0,6'd0);
        vecs[8]  = mk(0,1,5'd0,32'd265,      0,5'd0,5'd0,5'd2, 32'h0,32'hDEADBEEF, 0,0,0,6'd0);
        vecs[9]  = mk(0,0,5'd0,32'h0,        0,5'd0,5'd0,5'd1, 32'h0,32'd265, 0,0,0,6'd0);
        vecs[10] = mk(0,0,5'd0,32'h0,        1,5'd0,5'd0,5'd0, 32'h0,32'h0, 0,0,0,6'd0);
        vecs[11] = mk(0,0,5'd0,32'h0,        0,5'd0,5'd0,5'd0, 32'h0,32'h0, 0,0,0,6'd0);
        vecs[12] = mk(0,1,5'd5,32'h55,       0,5'd0,5'd5,5'd0, BP?32'h55:32'h0,32'h0, 0,0,0,6'd0);
        vecs[13] = mk(0,0,5'd0,32'h0,        0,5'd0,5'd5,5'd0, 32'h55,32'h0, 0,0,0,6'd0);
        vecs[14] = mk(0,0,5'd0,32'h0,        1,5'd7,5'd7,5'd1, 32'h0,32'd265, 0,0,0,6'd0);
        vecs[15] = mk(0,0,5'd0,32'h0,        0,5'd0,5'd7,5'd1, 32'h0,32'd265, 1,0,1,6'd1);
        vecs[16] = mk(0,1,5'd7,32'h77,       0,5'd0,5'd7,5'd7, BP?32'h77:32'h0,BP?32'h77:32'h0,
                      !BP,!BP,!BP,6'd1);
        vecs[17] = mk(0,0,5'd0,32'h0,        0,5'd0,5'd7,5'd2, 32'h77,32'hDEADBEEF, 0,0,0,6'd0);
        vecs[18] = mk(0,1,5'd7,32'h78,       1,5'd7,5'd2,5'd7, 32'hDEADBEEF,BP?32'h78:32'h77, 0,0,0,6'd0);
        vecs[19] = mk(0,0,5'd0,32'h0,        0,5'd0,5'd2,5'd7, 32'hDEADBEEF,32'h78, 0,1,1,6'd1);
        vecs[20] = mk(0,1,5'd7,32'h79,       0,5'd0,5'd7,5'd2, BP?32'h79:32'h78,32'hDEADBEEF,
                      !BP,0,!BP,6'd1);
        vecs[21] = mk(0,0,5'd0,32'h0,        0,5'd0,5'd7,5'd2, 32'h79,32'hDEADBEEF, 0,0,0,6'd0);
        vecs[22] = mk(0,1,5'd9,32'h9,        0,5'd0,5'd9,5'd7, BP?32'h9:32'h0,32'h79, 0,0,0,6'd0);
        vecs[23] = mk(0,0,5'd0,32'h0,        0,5'd0,5'd9,5'd7, 32'h9,32'h79, 0,0,0,6'd0);

        @(posedge clk);
        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].rst, vecs[i].we, vecs[i].ws, vecs[i].wd,
                  vecs[i].v, vecs[i].d, vecs[i].a, vecs[i].b);
            push(0, $sformatf("vec%0d", i), vecs[i].e1, vecs[i].e2,
                 vecs[i].eb1, vecs[i].eb2, vecs[i].ehz, vecs[i].ecnt, 1'b1);
            settle_and_check();
        end

        // Register 0 is ordinary storage when ZERO_REG=0
        drive(1, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
        drive(0, 1, 5'd0, 32'hAB, 0, 5'd0, 5'd0, 5'd0);
        push(0, "r0w_z", 32'h0, 32'h0, 0, 0, 0, 6'd0, 1'b1);
        push(1, "r0w_n", BP ? 32'hAB : 32'h0, BP ? 32'hAB : 32'h0, 0, 0, 0, 6'd0, 1'b1);
        settle_and_check();
        drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
        push(0, "r0r_z", 32'h0, 32'h0, 0, 0, 0, 6'd0, 1'b1);
        push(1, "r0r_n", 32'hAB, 32'hAB, 0, 0, 0, 6'd0, 1'b1);
        settle_and_check();

        // Fill the scoreboard one register per cycle
        drive(1, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 5'd0, 32'h0, 1, 5'(i), 5'd0, 5'd0);
            push(0, $sformatf("fill%0d_z", i), 32'h0, 32'h0, 0, 0, 0,
                 (i == 0) ? 6'd0 : 6'(i - 1), 1'b0);
            push(1, $sformatf("fill%0d_n", i), 32'h0, 32'h0, 0, 0, 0, 6'(i), 1'b0);
            settle_and_check();
        end
        drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd31);
        push(0, "full_z", 32'h0, 32'h0, 0, 1, 1, 6'd31, 1'b1);
        push(1, "full_n", 32'h0, 32'h0, 1, 1, 1, 6'd32, 1'b1);
        settle_and_check();
        drive(0, 0, 5'd0, 32'h0, 1, 5'd3, 5'd3, 5'd0);
        push(0, "reiss_z", 32'h0, 32'h0, 1, 0, 1, 6'd31, 1'b1);
        push(1, "reiss_n", 32'h0, 32'h0, 1, 1, 1, 6'd32, 1'b1);
        settle_and_check();
        drive(1, 1, 5'd4, 32'h4, 1, 5'd3, 5'd3, 5'd4);
        push(0, "sat_z", 32'h0, 32'h0, 0, 0, 0, 6'd31, 1'b0);
        push(1, "sat_n", 32'h0, 32'h0, 0, 0, 0, 6'd32, 1'b0);
        settle_and_check();
        drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd3, 5'd4);
        push(0, "rst_z", 32'h0, 32'h0, 0, 0, 0, 6'd0, 1'b1);
        push(1, "rst_n", 32'h0, 32'h0, 0, 0, 0, 6'd0, 1'b1);
        settle_and_check();

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regs_sb.md
# regs_sb

Parametrised successor of the core register file: DATA_W-bit registers, 2**ADDR_W entries, two asynchronous read ports, one write port with explicit enable, and a per-register busy scoreboard. It sits in the core's decode/writeback path. It serves operands to decode and flags read-after-write hazards against in-flight producers so the pipeline can stall.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register select width; depth = 2**ADDR_W
- ZERO_REG, 1, 1: register 0 reads as zero, ignores writes, is never busy; 0: register 0 is ordinary

- i_CLK  in  1  clock; all state updates on rising edge
- i_RST  in  1  synchronous, active-high reset
- i_reg_1_sel  in  ADDR_W  read port 1 select
- i_reg_2_sel  in  ADDR_W  read port 2 select
- o_reg_1  out  DATA_W  read port 1 data
- o_reg_2  out  DATA_W  read port 2 data
- i_reg_w_en  in  1  writeback enable
- i_reg_w_sel  in  ADDR_W  writeback destination
- i_reg_w_data  in  DATA_W  writeback data
- i_issue_valid  in  1  instruction issued this cycle with destination i_issue_rd
- i_issue_rd  in  ADDR_W  destination of issued instruction
- o_reg_1_busy  out  1  register selected on port 1 has a pending producer
- o_reg_2_busy  out  1  same for port 2
- o_hazard  out  1  o_reg_1_busy OR o_reg_2_busy
- o_busy_cnt  out  ADDR_W+1  number of busy registers

## Operation
- Storage: array regs[0..2**ADDR_W-1], busy vector busy[], counter busy_cnt.
- Reset (i_RST=1 at edge): all regs = 0, busy = 0, busy_cnt = 0. Reset overrides writeback and issue in the same cycle.
- Write: at the edge with i_reg_w_en=1, regs[i_reg_w_sel] <= i_reg_w_data. With ZERO_REG=1 and sel 0: no write.
- Read: purely combinational from regs; ZERO_REG=1 forces port data 0 for sel 0.
- Scoreboard, per register n at each edge (reset excluded):
  - set = i_issue_valid and i_issue_rd==n.
  - clr = i_reg_w_en and i_reg_w_sel==n.
  - set wins over clr: a new producer supersedes the retiring one.
  - With ZERO_REG=1, n=0 is never set.
- busy_cnt: +1 on a 0->1 transition, -1 on a 1->0 transition, unchanged when both or neither occur. Never wraps; max 2**ADDR_W.
- Clearing a non-busy register is legal and leaves busy_cnt unchanged.
- Busy outputs: o_reg_k_busy = busy[i_reg_k_sel]. The bypass (see Configuration) masks the bit when the writeback hits the same register in that cycle.

## Timing
- After a reset edge, all outputs are 0.
- Write latency: data written at edge N is visible on read ports after edge N (combinational). Same-cycle visibility depends on REGS_BYPASS_EN.
- Issue at edge N: busy visible after edge N. Writeback at edge M clears busy after edge M.
- No handshake backpressure. The block never stalls; o_hazard is advisory to the pipeline control.

## Configuration
- REGS_BYPASS_EN defined:
  - A read whose select equals i_reg_w_sel while i_reg_w_en=1 returns i_reg_w_data in the same cycle. Not applied to reg 0 when ZERO_REG=1.
  - The matching o_reg_k_busy is forced 0 that cycle.
- Undefined: reads return the pre-edge stored value, and busy reflects the registered bit only.

## Test plan
- Reset: write regs 1..3, then pulse i_RST for 1 cycle while i_reg_w_en=1 to reg 4 -> all reads 0, reg 4 = 0, o_busy_cnt=0.
- Write/read: write 265 to reg 1, then 0xDEADBEEF to reg 2; sel1=1, sel2=2 -> o_reg_1=265, o_reg_2=0xDEADBEEF.
- Zero register: write 265 to reg 0 -> o_reg_1=0 with sel 0. Issue rd=0 -> busy stays 0 and o_busy_cnt=0.
- Bypass: in the same cycle write 0x55 to reg 5 with sel1=5.
  - With REGS_BYPASS_EN: o_reg_1=0x55 and o_reg_1_busy=0.
  - Without it: old value, and 0x55 appears after the edge.
- Scoreboard:
  - Issue rd=7 -> o_reg_1_busy=1, o_hazard=1, o_busy_cnt=1.
  - Writeback reg 7 -> busy 0, o_busy_cnt=0.
  - Issue rd=7 and writeback reg 7 in the same cycle -> busy stays 1, o_busy_cnt=1.
- Counter saturation: issue all 32 registers with ZERO_REG=0 -> o_busy_cnt=32. Reissue reg 3 -> o_busy_cnt stays 32. Mid-stream reset -> o_busy_cnt=0.
